sobol_rng_multi_dim: RTL and testbench

Parametrised multi-dimension Sobol sequence generator for the stochastic-computing datapath. It uses one shared counter and least-significant-zero index to drive NDIM independent Gray-code XOR accumulators, one per dimension. Direction vectors and per-dimension digital-shift scramble masks are runtime-programmable. A synchronous restart and a period-wrap pulse let several generators stay aligned across bitstream frames.

---
 rtl/sobol_rng_multi_dim.sv | 105 ++++++++++
 tb/tb_sobol_rng_multi_dim.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sobol_rng_multi_dim.sv
// Multi-dimension Sobol generator: one shared counter and lowest-zero index drive
// NDIM Gray-code XOR accumulators, each with programmable direction vectors and a scramble mask.
module sobol_rng_multi_dim #(
  parameter int RWID = 8,
  parameter int NDIM = 2,
  parameter int RWL2 = $clog2(RWID),
  parameter int DWL2 = (NDIM > 1 ? $clog2(NDIM) : 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 restart,
  input  logic                 cfg_we,
  input  logic [DWL2-1:0]      cfg_dim,
  input  logic [RWL2-1:0]      cfg_idx,
  input  logic [RWID-1:0]      cfg_data,
  input  logic                 scr_we,
  input  logic [DWL2-1:0]      scr_dim,
  input  logic [RWID-1:0]      scr_data,
  output logic [NDIM*RWID-1:0] sobolSeq,
  output logic [RWID-1:0]      cntNum,
  output logic                 wrap
);

  localparam logic [DWL2:0] NDIM_L = (DWL2+1)'(NDIM);
  localparam logic [RWL2:0] RWID_L = (RWL2+1)'(RWID);

  logic [RWID-1:0] cnt_q, cnt_d;
  logic            wrap_q, wrap_d;
  logic [RWID-1:0] acc_q  [NDIM];
  logic [RWID-1:0] acc_d  [NDIM];
  logic [RWID-1:0] mask_q [NDIM];
  logic [RWID-1:0] mask_d [NDIM];
  logic [RWID-1:0] dir_q  [NDIM][RWID];
  logic [RWID-1:0] dir_d  [NDIM][RWID];
  logic [RWL2-1:0] lsz;
  logic            cfg_ok, scr_ok;

  // Scanning downward leaves the lowest zero position in lsz.
  always_comb begin
    lsz = '0;
    for (int i = RWID-1; i >= 0; i--) begin
      if (!cnt_q[i]) lsz = RWL2'(i);
    end
  end

  assign cfg_ok = ({1'b0, cfg_dim} < NDIM_L) && ({1'b0, cfg_idx} < RWID_L);
  assign scr_ok = ({1'b0, scr_dim} < NDIM_L);

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    for (int d = 0; d < NDIM; d++) begin
      acc_d[d]  = acc_q[d];
      mask_d[d] = mask_q[d];
      for (int i = 0; i < RWID; i++) dir_d[d][i] = dir_q[d][i];
    end

    if (restart) begin
      cnt_d = '0;
      for (int d = 0; d < NDIM; d++) acc_d[d] = '0;
    end else if (enable) begin
      // An all-ones counter has no zero bit: the period closes and everything returns to 0.
      if (&cnt_q) begin
        cnt_d  = '0;
        wrap_d = 1'b1;
        for (int d = 0; d < NDIM; d++) acc_d[d] = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
        for (int d = 0; d < NDIM; d++) acc_d[d] = acc_q[d] ^ dir_q[d][lsz];
      end
    end

    if (cfg_we && cfg_ok) dir_d[cfg_dim][cfg_idx] = cfg_data;
    if (scr_we && scr_ok) mask_d[scr_dim] = scr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      for (int d = 0; d < NDIM; d++) begin
        acc_q[d]  <= '0;
        mask_q[d] <= '0;
        for (int i = 0; i < RWID; i++) dir_q[d][i] <= RWID'(1) << (RWID-1-i);
      end
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      for (int d = 0; d < NDIM; d++) begin
        acc_q[d]  <= acc_d[d];
        mask_q[d] <= mask_d[d];
        for (int i = 0; i < RWID; i++) dir_q[d][i] <= dir_d[d][i];
      end
    end
  end

  for (genvar g = 0; g < NDIM; g++) begin : g_out
    assign sobolSeq[g*RWID +: RWID] = acc_q[g] ^ mask_q[g];
  end

  assign cntNum = cnt_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_sobol_rng_multi_dim.sv
// Bench for sobol_rng_multi_dim (RWID=3, NDIM=2): directed scenarios plus random traffic
// against a Gray-code based reference model.
module tb_sobol_rng_multi_dim;
  localparam int RWID = 3;
  localparam int NDIM = 2;
  localparam int RWL2 = 2;
  localparam int DWL2 = 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 enable, restart, cfg_we, scr_we;
  logic [DWL2-1:0]      cfg_dim, scr_dim;
  logic [RWL2-1:0]      cfg_idx;
  logic [RWID-1:0]      cfg_data, scr_data;
  logic [NDIM*RWID-1:0] sobolSeq;
  logic [RWID-1:0]      cntNum;
  logic                 wrap;

  int n_checks = 0;
  int n_fail   = 0;

  int m_cnt;
  int m_wrap;
  int m_acc  [NDIM];
  int m_mask [NDIM];
  int m_dir  [NDIM][RWID];

  int vdc [9] = '{0, 4, 6, 2, 3, 7, 5, 1, 0};
  int t2  [9] = '{0, 4, 2, 6, 3, 7, 1, 5, 0};
  int t3  [9] = '{7, 3, 1, 5, 4, 0, 2, 6, 7};
  int vec1[3] = '{4, 6, 5};

  sobol_rng_multi_dim #(.RWID(RWID), .NDIM(NDIM)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .restart(restart),
    .cfg_we(cfg_we), .cfg_dim(cfg_dim), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .scr_we(scr_we), .scr_dim(scr_dim), .scr_data(scr_data),
    .sobolSeq(sobolSeq), .cntNum(cntNum), .wrap(wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic int gray(int n);
    return n ^ (n >> 1);
  endfunction

  function automatic logic [RWID-1:0] dimv(int d);
    return sobolSeq[d*RWID +: RWID];
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_wrap = 0;
    for (int d = 0; d < NDIM; d++) begin
      m_acc[d]  = 0;
      m_mask[d] = 0;
      for (int i = 0; i < RWID; i++) m_dir[d][i] = 1 << (RWID-1-i);
    end
  endtask

  // The direction vector used at step n is the one for the Gray-code bit that flips from n to n+1.
  task automatic model_step();
    int k;
    if (restart) begin
      m_cnt = 0; m_wrap = 0;
      for (int d = 0; d < NDIM; d++) m_acc[d] = 0;
    end else if (enable) begin
      if (m_cnt == (1 << RWID) - 1) begin
        m_cnt = 0; m_wrap = 1;
        for (int d = 0; d < NDIM; d++) m_acc[d] = 0;
      end else begin
        k = $clog2(gray(m_cnt) ^ gray(m_cnt + 1));
        for (int d = 0; d < NDIM; d++) m_acc[d] = m_acc[d] ^ m_dir[d][k];
        m_cnt = m_cnt + 1; m_wrap = 0;
      end
    end else begin
      m_wrap = 0;
    end
    if (cfg_we && int'(cfg_dim) < NDIM && int'(cfg_idx) < RWID) m_dir[cfg_dim][cfg_idx] = int'(cfg_data);
    if (scr_we && int'(scr_dim) < NDIM) m_mask[scr_dim] = int'(scr_data);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < NDIM; d++)
      check($sformatf("%s seq%0d", tag, d), 32'(dimv(d)), 32'((m_acc[d] ^ m_mask[d]) & ((1 << RWID) - 1)));
    check({tag, " cnt"}, 32'(cntNum), 32'(m_cnt));
    check({tag, " wrap"}, 32'(wrap), 32'(m_wrap));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; restart = 1'b0; cfg_we = 1'b0; scr_we = 1'b0;
    cfg_dim = '0; cfg_idx = '0; cfg_data = '0; scr_dim = '0; scr_data = '0;
    model_reset();
    #2;
    check_all("reset");
    check("reset seq", 32'(sobolSeq), 32'd0);
    #10 rst_n = 1'b1;

    // 1: default van der Corput on both dimensions, wrap pulse on return to 0
    enable = 1'b1;
    check("t1 d0 start", 32'(dimv(0)), 32'(vdc[0]));
    for (int i = 1; i <= 8; i++) begin
      tick("t1");
      check($sformatf("t1 d0 step%0d", i), 32'(dimv(0)), 32'(vdc[i]));
      check($sformatf("t1 d1 step%0d", i), 32'(dimv(1)), 32'(vdc[i]));
      check($sformatf("t1 wrap step%0d", i), 32'(wrap), 32'(i == 8));
    end

    // 2: program dim1 vectors, restart, run
    enable = 1'b0;
    cfg_we = 1'b1; cfg_dim = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cfg_idx = RWL2'(i); cfg_data = RWID'(vec1[i]);
      tick("t2 cfg");
    end
    cfg_we = 1'b0; restart = 1'b1;
    tick("t2 restart");
    restart = 1'b0; enable = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick("t2");
      check($sformatf("t2 d1 step%0d", i), 32'(dimv(1)), 32'(t2[i]));
      check($sformatf("t2 d0 step%0d", i), 32'(dimv(0)), 32'(vdc[i]));
    end

    // 3: scramble mask on dim0
    enable = 1'b0; scr_we = 1'b1; scr_dim = 1'b0; scr_data = 3'b111;
    tick("t3 scr");
    scr_we = 1'b0;
    check("t3 d0 start", 32'(dimv(0)), 32'(t3[0]));
    enable = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick("t3");
      check($sformatf("t3 d0 step%0d", i), 32'(dimv(0)), 32'(t3[i]));
      check($sformatf("t3 d1 step%0d", i), 32'(dimv(1)), 32'(t2[i]));
    end

    // 4: enable hold and restart-over-enable
    enable = 1'b0; scr_we = 1'b1; scr_data = '0; restart = 1'b1;
    tick("t4 clr");
    scr_we = 1'b0; restart = 1'b0; enable = 1'b1;
    tick("t4 a");
    tick("t4 b");
    check("t4 reach6", 32'(dimv(0)), 32'd6);
    enable = 1'b0;
    tick("t4 hold1");
    check("t4 hold1 d0", 32'(dimv(0)), 32'd6);
    tick("t4 hold2");
    check("t4 hold2 d0", 32'(dimv(0)), 32'd6);
    enable = 1'b1;
    tick("t4 adv");
    check("t4 adv d0", 32'(dimv(0)), 32'd2);
    tick("t4 adv3");
    check("t4 at3 d0", 32'(dimv(0)), 32'd3);
    restart = 1'b1;
    tick("t4 rst");
    check("t4 rst cnt", 32'(cntNum), 32'd0);
    check("t4 rst d0", 32'(dimv(0)), 32'd0);
    check("t4 rst wrap", 32'(wrap), 32'd0);
    restart = 1'b0;

    // 5: write during a step uses the old vector; out-of-range index ignored
    cfg_we = 1'b1; cfg_dim = 1'b0; cfg_idx = 2'd0; cfg_data = 3'd1;
    tick("t5 wr");
    check("t5 wr step d0", 32'(dimv(0)), 32'd4);
    cfg_we = 1'b0;
    tick("t5 s2");
    tick("t5 s3");
    check("t5 new vec d0", 32'(dimv(0)), 32'd7);
    enable = 1'b0; cfg_we = 1'b1; cfg_dim = 1'b1; cfg_idx = 2'd3; cfg_data = 3'd7;
    tick("t5 oor");
    cfg_we = 1'b0; restart = 1'b1;
    tick("t5 restart");
    restart = 1'b0; enable = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick("t5 run");
      check($sformatf("t5 d1 step%0d", i), 32'(dimv(1)), 32'(t2[i]));
    end

    // 6: asynchronous reset mid-period restores defaults
    enable = 1'b0; scr_we = 1'b1; scr_dim = 1'b1; scr_data = 3'd5;
    tick("t6 m1");
    scr_dim = 1'b0; scr_data = 3'd3;
    tick("t6 m0");
    scr_we = 1'b0; enable = 1'b1;
    tick("t6 a");
    tick("t6 b");
    tick("t6 c");
    enable = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("t6 async seq", 32'(sobolSeq), 32'd0);
    check_all("t6 async");
    @(negedge clk);
    rst_n = 1'b1; enable = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick("t6 run");
      check($sformatf("t6 d0 step%0d", i), 32'(dimv(0)), 32'(vdc[i]));
      check($sformatf("t6 d1 step%0d", i), 32'(dimv(1)), 32'(vdc[i]));
    end

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      enable   = ($urandom_range(0, 3) != 0);
      restart  = ($urandom_range(0, 15) == 0);
      cfg_we   = ($urandom_range(0, 7) == 0);
      cfg_dim  = DWL2'($urandom_range(0, 1));
      cfg_idx  = RWL2'($urandom_range(0, 3));
      cfg_data = RWID'($urandom);
      scr_we   = ($urandom_range(0, 7) == 0);
      scr_dim  = DWL2'($urandom_range(0, 1));
      scr_data = RWID'($urandom);
      tick("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
